packet_crossbar: RTL and testbench

PACKET_CROSSBAR -- requirements
Module: packet_crossbar

---
 rtl/packet_crossbar_pkg.sv | 40 ++++
 rtl/packet_crossbar_out_fifo.sv | 65 ++++++
 rtl/packet_crossbar.sv | 174 +++++++++++++++++
 tb/tb_packet_crossbar.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_crossbar_pkg.sv
// Shared constants and helpers for the packet crossbar.
// Holds the drop-counter sizing and the round-robin search.
package packet_crossbar_pkg;

  localparam int DROP_CNT_W = 32;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // Upper bound on inputs the round-robin search handles.
  localparam int MAX_PORTS  = 32;
  localparam int PORT_IDX_W = 5;

  typedef struct packed {
    logic                  found;
    logic [PORT_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or cyclically after ptr, among n bits.
  function automatic rr_pick_t rr_search(
    input logic [MAX_PORTS-1:0] req,
    input int                   ptr,
    input int                   n
  );
    rr_pick_t pick;
    int       j;
    pick = '0;
    // Walk from the farthest candidate down so the nearest wins.
    for (int k = MAX_PORTS - 1; k >= 0; k--) begin
      if (k < n) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (req[j[PORT_IDX_W-1:0]]) begin
          pick.found = 1'b1;
          pick.idx   = j[PORT_IDX_W-1:0];
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/packet_crossbar_out_fifo.sv
// Per-output beat FIFO for the packet crossbar.
// Head is shown combinationally; full/empty come from a count.
module xbar_out_fifo
  import packet_crossbar_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];

  // Next pointers and occupancy; depth is a power of two so
  // the pointers wrap naturally.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop)
      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push)
      cnt_d = cnt_q - 1'b1;
  end

  // Pointer and count state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/packet_crossbar.sv
// Packet crossbar: N inputs to M outputs with per-output
// round-robin arbitration, packet locking and output FIFOs.
module packet_crossbar
  import packet_crossbar_pkg::*;
#(
  parameter int DATA_WIDTH    = 512,
  parameter int NUM_INPUTS    = 4,
  parameter int NUM_OUTPUTS   = 4,
  parameter int TAG_WIDTH     =
    (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1,
  parameter int OUT_DEPTH     = 4,
  parameter int LAST_HANDLING = 1,
  parameter int FILTER_KEEP   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_INPUTS*DATA_WIDTH/8-1:0] in_keep,
  input  logic [NUM_INPUTS*TAG_WIDTH-1:0]    in_tag,
  input  logic [NUM_INPUTS-1:0]              in_last,
  input  logic [NUM_INPUTS-1:0]              in_valid,
  output logic [NUM_INPUTS-1:0]              in_ready,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0]   out_data,
  output logic [NUM_OUTPUTS*DATA_WIDTH/8-1:0] out_keep,
  output logic [NUM_OUTPUTS-1:0]              out_last,
  output logic [NUM_OUTPUTS-1:0]              out_valid,
  input  logic [NUM_OUTPUTS-1:0]              out_ready,
  output logic [DROP_CNT_W-1:0]               drop_cnt
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int IW =
    (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int FW = DATA_WIDTH + KW + 1;

  logic [TAG_WIDTH-1:0]   tag      [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]  oob;
  logic [MAX_PORTS-1:0]   req      [NUM_OUTPUTS];
  rr_pick_t               pick     [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0] gnt_vld;
  logic [IW-1:0]          gnt_idx  [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0] zero_keep;
  logic [NUM_OUTPUTS-1:0] push, pop, full, empty;
  logic [FW-1:0]          wdata    [NUM_OUTPUTS];
  logic [FW-1:0]          rdata    [NUM_OUTPUTS];
  logic [NUM_INPUTS-1:0]  rdy;

  logic [IW-1:0]          rr_ptr_q [NUM_OUTPUTS];
  logic [IW-1:0]          rr_ptr_d [NUM_OUTPUTS];
  logic [IW-1:0]          owner_q  [NUM_OUTPUTS];
  logic [IW-1:0]          owner_d  [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0] lock_q, lock_d;

  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [DROP_CNT_W:0]    drop_sum;

  // Split tags and flag beats aimed past the last output.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      tag[i] = in_tag[i*TAG_WIDTH +: TAG_WIDTH];
      oob[i] = in_valid[i] &&
               (32'(tag[i]) >= NUM_OUTPUTS);
    end
  end

  // Per-output arbitration, FIFO write and lock bookkeeping.
  always_comb begin
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < NUM_INPUTS; i++)
        req[o][i] = in_valid[i] && !oob[i] &&
                    (32'(tag[i]) == o);
      pick[o] = rr_search(req[o], int'(rr_ptr_q[o]),
                          NUM_INPUTS);
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = owner_q[o];
      if (!full[o]) begin
        if (lock_q[o]) begin
          gnt_vld[o] =
            req[o][PORT_IDX_W'(owner_q[o])];
        end else begin
          gnt_vld[o] = pick[o].found;
          gnt_idx[o] = IW'(pick[o].idx);
        end
      end
      wdata[o] = {
        in_last[gnt_idx[o]],
        in_keep[gnt_idx[o]*KW +: KW],
        in_data[gnt_idx[o]*DATA_WIDTH +: DATA_WIDTH]
      };
      zero_keep[o] = (FILTER_KEEP != 0) &&
        (in_keep[gnt_idx[o]*KW +: KW] == '0);
      push[o] = gnt_vld[o] && !zero_keep[o] && !rst;
      lock_d[o]   = lock_q[o];
      owner_d[o]  = owner_q[o];
      rr_ptr_d[o] = rr_ptr_q[o];
      if (gnt_vld[o]) begin
        if (LAST_HANDLING != 0 &&
            !in_last[gnt_idx[o]]) begin
          lock_d[o]  = 1'b1;
          owner_d[o] = gnt_idx[o];
        end else begin
          lock_d[o] = 1'b0;
          if (gnt_idx[o] == IW'(NUM_INPUTS - 1))
            rr_ptr_d[o] = '0;
          else
            rr_ptr_d[o] = gnt_idx[o] + 1'b1;
        end
      end
    end
  end

  // Ready is grant or drop; held low throughout reset.
  always_comb begin
    rdy = oob;
    for (int o = 0; o < NUM_OUTPUTS; o++)
      if (gnt_vld[o]) rdy[gnt_idx[o]] = 1'b1;
    in_ready = rst ? '0 : rdy;
  end

  // Saturating count of out-of-range beats.
  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < NUM_INPUTS; i++)
      if (oob[i]) drop_sum = drop_sum + 1'b1;
    drop_cnt_d = drop_sum[DROP_CNT_W] ? DROP_CNT_MAX
               : drop_sum[DROP_CNT_W-1:0];
  end

  // Arbiter and counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        rr_ptr_q[o] <= '0;
        owner_q[o]  <= '0;
      end
      lock_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        rr_ptr_q[o] <= rr_ptr_d[o];
        owner_q[o]  <= owner_d[o];
      end
      lock_q     <= lock_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt  = drop_cnt_q;
  assign pop       = ~empty & out_ready;
  assign out_valid = ~empty;

  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
    xbar_out_fifo #(
      .WIDTH (FW),
      .DEPTH (OUT_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[o]),
      .wdata (wdata[o]),
      .pop   (pop[o]),
      .rdata (rdata[o]),
      .full  (full[o]),
      .empty (empty[o])
    );
    assign out_data[o*DATA_WIDTH +: DATA_WIDTH] =
      rdata[o][DATA_WIDTH-1:0];
    assign out_keep[o*KW +: KW] =
      rdata[o][DATA_WIDTH +: KW];
    assign out_last[o] = rdata[o][FW-1];
  end

endmodule

// File: tb/tb_packet_crossbar.sv
// Directed testbench for packet_crossbar.
// Inputs change at posedge+1; outputs are read there too.
module tb_packet_crossbar;

  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int NI = 4;
  localparam int NO = 4;
  localparam int TW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NI*DW-1:0]  in_data;
  logic [NI*KW-1:0]  in_keep;
  logic [NI*TW-1:0]  in_tag;
  logic [NI-1:0]     in_last;
  logic [NI-1:0]     in_valid;
  logic [NI-1:0]     in_ready;
  logic [NO*DW-1:0]  out_data;
  logic [NO*KW-1:0]  out_keep;
  logic [NO-1:0]     out_last;
  logic [NO-1:0]     out_valid;
  logic [NO-1:0]     out_ready;
  logic [31:0]       drop_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  packet_crossbar #(
    .DATA_WIDTH    (DW),
    .NUM_INPUTS    (NI),
    .NUM_OUTPUTS   (NO),
    .TAG_WIDTH     (TW),
    .OUT_DEPTH     (4),
    .LAST_HANDLING (1),
    .FILTER_KEEP   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .in_tag    (in_tag),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_data  = '0;
    in_keep  = '0;
    in_tag   = '0;
    in_last  = '0;
    in_valid = '0;
  endtask

  task automatic drive(input int i, input int t,
                       input logic [31:0] d,
                       input logic [3:0] k,
                       input logic l);
    in_data[i*DW +: DW] = d;
    in_keep[i*KW +: KW] = k;
    in_tag[i*TW +: TW]  = t[TW-1:0];
    in_last[i]          = l;
    in_valid[i]         = 1'b1;
  endtask

  function automatic logic [31:0] odata(input int o);
    return out_data[o*DW +: DW];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    out_ready = '1;
    clear_in();
    drive(0, 0, 32'h1, 4'hF, 1'b1);
    drive(1, 7, 32'h2, 4'hF, 1'b1);
    repeat (2) cyc();
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL rst_ready got %b want 0000", in_ready);
    end
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++;
      $display("FAIL rst_valid got %b want 0000", out_valid);
    end
    checks++;
    if (drop_cnt !== 32'd0) begin
      failures++;
      $display("FAIL rst_drop got %0d want 0", drop_cnt);
    end
    clear_in();
    rst = 1'b0;
    cyc();
    drive(0, 0, 32'h3, 4'hF, 1'b1);
    drive(1, 0, 32'h4, 4'hF, 1'b1);
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rst_rr0 got %b want 0001", in_ready);
    end
    cyc();
    in_valid[0] = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++;
      $display("FAIL rst_rr1 got %b want 0010", in_ready);
    end
    cyc();
    clear_in();
    repeat (2) cyc();
  endtask

  task automatic test_single_beat();
    out_ready = '1;
    clear_in();
    drive(0, 2, 32'hA5, 4'hF, 1'b1);
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_ready got %b want 0001", in_ready);
    end
    cyc();
    clear_in();
    checks++;
    if (out_valid !== 4'b0100) begin
      failures++;
      $display("FAIL single_valid got %b want 0100", out_valid);
    end
    checks++;
    if (odata(2) !== 32'hA5) begin
      failures++;
      $display("FAIL single_data got %h want a5", odata(2));
    end
    checks++;
    if (out_last[2] !== 1'b1) begin
      failures++;
      $display("FAIL single_last got %b want 1", out_last[2]);
    end
    cyc();
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++;
      $display("FAIL single_idle got %b want 0000", out_valid);
    end
  endtask

  task automatic test_contention();
    logic [31:0] exp_d [6];
    logic [NI-1:0] r;
    int p0 = 0;
    int p1 = 0;
    int k  = 0;
    exp_d = '{32'h10, 32'h11, 32'h12,
              32'h20, 32'h21, 32'h22};
    out_ready = '1;
    for (int c = 0; c < 10; c++) begin
      clear_in();
      if (p0 < 3) drive(0, 1, 32'h10 + p0, 4'hF, p0 == 2);
      if (p1 < 3) drive(1, 1, 32'h20 + p1, 4'hF, p1 == 2);
      #1;
      r = in_ready;
      cyc();
      if (out_valid[1]) begin
        checks++;
        if (k > 5) begin
          failures++;
          $display("FAIL cont_extra got beat %h", odata(1));
        end else begin
          if (odata(1) !== exp_d[k]) begin
            failures++;
            $display("FAIL cont_data got %h want %h",
                     odata(1), exp_d[k]);
          end
          checks++;
          if (out_last[1] !== (k == 2 || k == 5)) begin
            failures++;
            $display("FAIL cont_last beat %0d got %b",
                     k, out_last[1]);
          end
        end
        k++;
      end
      if (r[0]) p0++;
      if (r[1]) p1++;
    end
    checks++;
    if (k !== 6) begin
      failures++;
      $display("FAIL cont_count got %0d want 6", k);
    end
    clear_in();
    drive(1, 1, 32'h31, 4'hF, 1'b1);
    drive(2, 1, 32'h32, 4'hF, 1'b1);
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL cont_rr2 got %b want 0100", in_ready);
    end
    cyc();
    in_valid[2] = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++;
      $display("FAIL cont_rr_next got %b want 0010", in_ready);
    end
    cyc();
    clear_in();
    checks++;
    if (odata(1) !== 32'h31) begin
      failures++;
      $display("FAIL cont_rr_data got %h want 31", odata(1));
    end
    repeat (2) cyc();
  endtask

  task automatic test_drop_filter();
    out_ready = '1;
    clear_in();
    drive(0, 7, 32'hDEAD, 4'hF, 1'b1);
    #1;
    checks++;
    if (in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL drop_ready got %b want 1", in_ready[0]);
    end
    cyc();
    clear_in();
    checks++;
    if (drop_cnt !== 32'd1) begin
      failures++;
      $display("FAIL drop_cnt got %0d want 1", drop_cnt);
    end
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++;
      $display("FAIL drop_idle got %b want 0000", out_valid);
    end
    drive(0, 0, 32'h60, 4'h0, 1'b0);
    drive(1, 0, 32'h61, 4'hF, 1'b1);
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL filt_grant got %b want 0001", in_ready);
    end
    cyc();
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++;
      $display("FAIL filt_hidden got %b want 0000", out_valid);
    end
    drive(0, 0, 32'h62, 4'h0, 1'b1);
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL filt_lock got %b want 0001", in_ready);
    end
    cyc();
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++;
      $display("FAIL filt_last got %b want 0000", out_valid);
    end
    in_valid[0] = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++;
      $display("FAIL filt_release got %b want 0010", in_ready);
    end
    cyc();
    clear_in();
    checks++;
    if (out_valid !== 4'b0001 || odata(0) !== 32'h61) begin
      failures++;
      $display("FAIL filt_out got %b/%h want 0001/61",
               out_valid, odata(0));
    end
    checks++;
    if (drop_cnt !== 32'd1) begin
      failures++;
      $display("FAIL drop_hold got %0d want 1", drop_cnt);
    end
    repeat (2) cyc();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    out_ready = 4'b0111;
    clear_in();
    for (int c = 0; c < 6; c++) begin
      drive(0, 3, 32'h30 + acc, 4'hF, 1'b0);
      #1;
      if (in_ready[0]) acc++;
      cyc();
    end
    checks++;
    if (acc !== 4) begin
      failures++;
      $display("FAIL bp_fill got %0d want 4", acc);
    end
    drive(0, 3, 32'h30 + acc, 4'hF, 1'b0);
    #1;
    checks++;
    if (in_ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall got %b want 0", in_ready[0]);
    end
    checks++;
    if (odata(3) !== 32'h30) begin
      failures++;
      $display("FAIL bp_head got %h want 30", odata(3));
    end
    out_ready = 4'b1111;
    cyc();
    out_ready = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      drive(0, 3, 32'h30 + acc, 4'hF, 1'b0);
      #1;
      if (in_ready[0]) acc++;
      cyc();
    end
    checks++;
    if (acc !== 5) begin
      failures++;
      $display("FAIL bp_pulse got %0d want 5", acc);
    end
    checks++;
    if (out_valid[3] !== 1'b1 || odata(3) !== 32'h31) begin
      failures++;
      $display("FAIL bp_head2 got %b/%h want 1/31",
               out_valid[3], odata(3));
    end
    clear_in();
  endtask

  task automatic test_reset_mid();
    out_ready = '0;
    clear_in();
    drive(0, 2, 32'h40, 4'hF, 1'b0);
    #1;
    checks++;
    if (in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_b1 got %b want 1", in_ready[0]);
    end
    cyc();
    drive(0, 2, 32'h41, 4'hF, 1'b0);
    cyc();
    clear_in();
    checks++;
    if (out_valid !== 4'b1100) begin
      failures++;
      $display("FAIL mid_pre got %b want 1100", out_valid);
    end
    drive(1, 2, 32'h50, 4'hF, 1'b1);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++;
      $display("FAIL mid_rst_valid got %b want 0000", out_valid);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL mid_rst_ready got %b want 0000", in_ready);
    end
    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++;
      $display("FAIL mid_post got %b want 0000", out_valid);
    end
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++;
      $display("FAIL mid_grant got %b want 0010", in_ready);
    end
    cyc();
    clear_in();
    checks++;
    if (out_valid !== 4'b0100 || odata(2) !== 32'h50 ||
        out_last[2] !== 1'b1) begin
      failures++;
      $display("FAIL mid_new got %b/%h/%b want 0100/50/1",
               out_valid, odata(2), out_last[2]);
    end
    out_ready = '1;
    cyc();
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++;
      $display("FAIL mid_stale got %b want 0000", out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_beat();
    test_contention();
    test_drop_filter();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
